// File: rtl/mem_cmd_responder_if.sv
// mem_cmd_responder_if
//   Request/response bundle between a memory command issuer and the responder.
//   Request channel : req_valid/req_ready handshake carrying req_op, req_addr, req_data.
//   Response channel: rsp_valid/rsp_ready handshake carrying rsp_data, rsp_err, rsp_wrap.
//   master modport  : issuer side (drives requests, consumes responses).
//   slave modport   : responder side.
interface mem_cmd_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              rsp_wrap;

    modport master (
        output req_valid, req_op, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_wrap
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_wrap
    );
endinterface

// File: rtl/mem_cmd_responder.sv
// mem_cmd_responder
//   Responder end of the memory command path. Serves read, write and increment
//   (read-modify-write) requests on a 2**ADDR_W x DATA_W single-port synchronous RAM.
//   Every accepted request yields exactly one response.
// Ports
//   clk   : system clock
//   BTNC  : synchronous active-high reset; aborts any operation in progress
//   bus   : mem_cmd_responder_if.slave request/response channels
//   busy  : RAM clear in progress or a request in flight
// Parameters
//   ADDR_W  : address width, RAM depth is 2**ADDR_W
//   DATA_W  : data word width
//   CLR_RST : 1 = zero the whole RAM after reset, 0 = go straight to IDLE
module mem_cmd_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4,
    parameter int CLR_RST = 1
) (
    input  logic                  clk,
    input  logic                  BTNC,
    mem_cmd_responder_if.slave    bus,
    output logic                  busy
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RD,
        S_INC_WR,
        S_RSP
    } state_t;

    // Modulo-2**DATA_W increment; the extra MSB is the wrap flag.
    function automatic logic [DATA_W:0] inc_wrap(input logic [DATA_W-1:0] v);
        return {1'b0, v} + (DATA_W+1)'(1);
    endfunction

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_cnt;
    logic              req_ready_r;
    logic              busy_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_err_r;
    logic              rsp_wrap_r;
    logic              acc;

    logic [1:0]        op_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_p1;
    logic [DATA_W:0]   inc_p1;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    // req_ready is registered, so it is only ever 1 while state is IDLE.
    assign acc    = (state == S_IDLE) && req_ready_r && bus.req_valid;
    assign inc_p1 = inc_wrap(rd_data_p1);

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_wrap  = rsp_wrap_r;
    assign busy          = busy_r;

    always_comb begin
        state_n   = state;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr_p0;
        ram_wdata = inc_p1[DATA_W-1:0];
        case (state)
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wdata = '0;
                if (clr_cnt == {ADDR_W{1'b1}}) state_n = S_IDLE;
            end
            S_IDLE: begin
                ram_addr  = bus.req_addr;
                ram_wdata = bus.req_data;
                if (acc) begin
                    case (bus.req_op)
                        OP_RD:   state_n = S_RD;
                        OP_INC:  state_n = S_RD;
                        OP_WR: begin
                            state_n = S_RSP;
                            ram_we  = 1'b1;
                        end
                        OP_NONE: state_n = S_RSP;
                    endcase
                end
            end
            S_RD: begin
                ram_re  = 1'b1;
                state_n = (op_p0 == OP_INC) ? S_INC_WR : S_RSP;
            end
            S_INC_WR: begin
                ram_we  = 1'b1;
                state_n = S_RSP;
            end
            S_RSP: begin
                if (rsp_valid_r && bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (BTNC) begin
            state       <= (CLR_RST != 0) ? S_CLEAR : S_IDLE;
            clr_cnt     <= '0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            rsp_wrap_r  <= 1'b0;
        end else begin
            state       <= state_n;
            req_ready_r <= (state_n == S_IDLE);
            busy_r      <= (state_n != S_IDLE);
            if (state == S_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
            // First RSP cycle builds the response; it is then held until taken.
            if (state == S_RSP) begin
                if (!rsp_valid_r) begin
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_wrap_r  <= 1'b0;
                    case (op_p0)
                        OP_RD:   rsp_data_r <= rd_data_p1;
                        OP_WR:   rsp_data_r <= data_p0;
                        OP_INC: begin
                            rsp_data_r <= inc_p1[DATA_W-1:0];
                            rsp_wrap_r <= inc_p1[DATA_W];
                        end
                        OP_NONE: begin
                            rsp_data_r <= '0;
                            rsp_err_r  <= 1'b1;
                        end
                    endcase
                end else if (bus.rsp_ready) begin
                    rsp_valid_r <= 1'b0;
                end
            end
        end
    end

    // Stage p0: request fields captured in the accept cycle only
    always_ff @(posedge clk) begin
        if (acc) begin
            op_p0   <= bus.req_op;
            addr_p0 <= bus.req_addr;
            data_p0 <= bus.req_data;
        end
    end

    // Stage p1: RAM access; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (ram_we && !BTNC) mem[ram_addr] <= ram_wdata;
        if (ram_re) rd_data_p1 <= mem[ram_addr];
    end

endmodule
